// File: rtl/escritor_solicitudes_if.sv
// Write-side FIFO bus of the floor-request path.
//   din_fifo/wr_en_fifo : floor number and write strobe toward sync_fifo
//   full_fifo           : FIFO full flag (same clock domain)
//   atendido_valid/piso : 1-cycle report of a floor served by the controller
// master = request writer, slave = FIFO/controller side.
interface escritor_solicitudes_if;
    logic [1:0] din_fifo;
    logic       wr_en_fifo;
    logic       full_fifo;
    logic       atendido_valid;
    logic [1:0] atendido_piso;

    modport master (
        output din_fifo, wr_en_fifo,
        input  full_fifo, atendido_valid, atendido_piso
    );

    modport slave (
        input  din_fifo, wr_en_fifo,
        output full_fifo, atendido_valid, atendido_piso
    );
endinterface

// File: rtl/escritor_solicitudes.sv
// Hall-call capture and FIFO writer.
//   clk, rst_n : clock, async active-low reset
//   btn        : raw per-floor call buttons (asynchronous)
//   bus        : FIFO write port + served-floor report (master modport)
//   pendiente  : captured calls waiting to be written to the FIFO
//   en_cola    : calls already in the FIFO, not yet served
//   descartes  : saturating count of duplicate calls dropped

// Per-button 2-FF synchronizer + debouncer; evento is a 1-cycle pulse on
// each rising edge of the debounced level.
module escritor_solicitudes_deb #(
    parameter int DEB_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic evento
);
    localparam logic [DEB_WIDTH-1:0] LIM = DEB_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [1:0]           sync;
    logic [DEB_WIDTH-1:0] cnt;
    logic                 nivel, nivel_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '0;
            cnt     <= '0;
            nivel   <= 1'b0;
            nivel_d <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            nivel_d <= nivel;
            if (sync[1] == nivel) begin
                cnt <= '0;
            end else if (cnt == LIM) begin
                nivel <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign evento = nivel & ~nivel_d;
endmodule

module escritor_solicitudes #(
    parameter int NUM_PISOS       = 4,
    parameter int DEB_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PISOS-1:0] btn,
    escritor_solicitudes_if.master bus,
    output logic [NUM_PISOS-1:0] pendiente,
    output logic [NUM_PISOS-1:0] en_cola,
    output logic [7:0]           descartes
);
    localparam int PW = $clog2(NUM_PISOS);

    typedef enum logic {IDLE, ESCRIBE} estado_t;

    typedef struct packed {
        logic          vld;
        logic [PW-1:0] piso;
    } sel_t;

    estado_t              estado, estado_sig;
    logic [PW-1:0]        rr_ptr;
    logic [NUM_PISOS-1:0] evento, clr, cola_vis, dup, nuevo, wr_msk;
    logic [NUM_PISOS-1:0] pend_sig, cola_sig;
    logic [7:0]           desc_sig;
    logic [8:0]           desc_sum;
    logic [PW:0]          n_dup;
    logic                 escribe;
    sel_t                 sel;

    for (genvar gi = 0; gi < NUM_PISOS; gi++) begin : g_deb
        escritor_solicitudes_deb #(
            .DEB_WIDTH       (DEB_WIDTH),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn    (btn[gi]),
            .evento (evento[gi])
        );
    end

    // First set bit of p, scanning upward from ptr with wrap-around.
    function automatic sel_t pick(input logic [NUM_PISOS-1:0] p, input logic [PW-1:0] ptr);
        sel_t          s;
        logic [PW-1:0] idx;
        s = '0;
        for (int off = 0; off < NUM_PISOS; off++) begin
            idx = ptr + PW'(off);
            if (!s.vld && p[idx]) begin
                s.vld  = 1'b1;
                s.piso = idx;
            end
        end
        return s;
    endfunction

    always_comb begin
        clr = '0;
        if (bus.atendido_valid) clr[bus.atendido_piso] = 1'b1;
        // Served clear lands before the duplicate check, so a call on a
        // floor being served in the same cycle is accepted as new.
        cola_vis = en_cola & ~clr;
        dup      = evento & (pendiente | cola_vis);
        nuevo    = evento & ~dup;

        n_dup = '0;
        for (int i = 0; i < NUM_PISOS; i++) n_dup = n_dup + (PW+1)'(dup[i]);
        desc_sum = {1'b0, descartes} + 9'(n_dup);
        desc_sig = desc_sum[8] ? 8'hFF : desc_sum[7:0];

        sel        = pick(pendiente, rr_ptr);
        escribe    = 1'b0;
        estado_sig = estado;
        case (estado)
            IDLE: begin
                if (sel.vld && !bus.full_fifo) begin
                    escribe    = 1'b1;
                    estado_sig = ESCRIBE;
                end
            end
            ESCRIBE: estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase

        wr_msk = '0;
        if (escribe) wr_msk[sel.piso] = 1'b1;
        // A written floor can never also take a new call this cycle:
        // pendiente was set for it, so that call is a duplicate.
        pend_sig = (pendiente & ~wr_msk) | nuevo;
        cola_sig = cola_vis | wr_msk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= IDLE;
        else        estado <= estado_sig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.din_fifo   <= '0;
            bus.wr_en_fifo <= 1'b0;
            rr_ptr         <= '0;
            pendiente      <= '0;
            en_cola        <= '0;
            descartes      <= '0;
        end else begin
            bus.wr_en_fifo <= escribe;
            if (escribe) begin
                bus.din_fifo <= sel.piso;
                rr_ptr       <= sel.piso + 1'b1;
            end
            pendiente <= pend_sig;
            en_cola   <= cola_sig;
            descartes <= desc_sig;
        end
    end
endmodule

// File: tb/tb_escritor_solicitudes.sv
module tb_escritor_solicitudes;
    localparam int D = 4;

    typedef struct {
        logic [1:0] din;
        int         cyc;
        logic       inv_ok;
    } wr_rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = '0;
    logic [3:0] pendiente, en_cola;
    logic [7:0] descartes;

    escritor_solicitudes_if bus();

    escritor_solicitudes #(
        .NUM_PISOS       (4),
        .DEB_WIDTH       (16),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn       (btn),
        .bus       (bus.master),
        .pendiente (pendiente),
        .en_cola   (en_cola),
        .descartes (descartes)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    wr_rec_t    obs[$];
    logic [1:0] exp_q[$];
    int         rd_idx = 0;
    int         tests = 0;
    int         fails = 0;
    int         first_cyc, last_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write the DUT makes; the tests consume the records.
    always @(negedge clk) begin
        if (rst_n && bus.wr_en_fifo)
            obs.push_back('{din: bus.din_fifo, cyc: cyc, inv_ok: ((pendiente & en_cola) == 4'b0)});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] m);
        btn = btn | m;
        tick(10);
        btn = btn & ~m;
        tick(10);
    endtask

    task automatic serve(input logic [1:0] p);
        bus.atendido_valid = 1'b1;
        bus.atendido_piso  = p;
        tick(1);
        bus.atendido_valid = 1'b0;
    endtask

    task automatic check_writes(input string nm, input int n, input int budget);
        int      waited;
        wr_rec_t r;
        logic [1:0] e;
        waited = 0;
        while (obs.size() < rd_idx + n && waited < budget) begin
            @(negedge clk); #1;
            waited++;
        end
        if (obs.size() < rd_idx + n) begin
            tests++; fails++;
            $display("FAIL %s timeout: got %0d writes, required %0d", nm, obs.size() - rd_idx, n);
            return;
        end
        for (int i = 0; i < n; i++) begin
            r = obs[rd_idx];
            rd_idx++;
            if (i == 0) first_cyc = r.cyc;
            last_cyc = r.cyc;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL %s unexpected write din=%0d", nm, r.din);
            end else begin
                e = exp_q.pop_front();
                if (r.din !== e) begin
                    fails++;
                    $display("FAIL %s din got %0d required %0d", nm, r.din, e);
                end
            end
            tests++;
            if (!r.inv_ok) begin
                fails++;
                $display("FAIL %s_invariant pendiente&en_cola nonzero at write", nm);
            end
        end
    endtask

    task automatic check_no_write(input string nm);
        tests++;
        if (obs.size() != rd_idx) begin
            fails++;
            $display("FAIL %s extra writes got %0d required 0", nm, obs.size() - rd_idx);
            rd_idx = obs.size();
        end
    endtask

    task automatic test_reset();
        bus.full_fifo = 1'b0; bus.atendido_valid = 1'b0; bus.atendido_piso = '0;
        #12;
        tests++;
        if ({bus.wr_en_fifo, bus.din_fifo, pendiente, en_cola, descartes} !== '0) begin
            fails++;
            $display("FAIL reset_state got wr=%b din=%0d pend=%b cola=%b desc=%0d required all 0",
                     bus.wr_en_fifo, bus.din_fifo, pendiente, en_cola, descartes);
        end
        @(negedge clk); rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_single_press();
        int c0;
        c0 = cyc;
        btn[2] = 1'b1;
        exp_q.push_back(2'd2);
        check_writes("single_wr", 1, 20);
        tests++;
        if (last_cyc - c0 != D + 4) begin
            fails++;
            $display("FAIL single_latency got %0d required %0d", last_cyc - c0, D + 4);
        end
        tick(6); btn[2] = 1'b0; tick(10);
        check_no_write("single_one_pulse");
        tests++;
        if (en_cola !== 4'b0100 || pendiente !== 4'b0000) begin
            fails++;
            $display("FAIL single_state got cola=%b pend=%b required 0100/0000", en_cola, pendiente);
        end
        serve(2'd2);
        tests++;
        if (en_cola !== 4'b0000) begin
            fails++;
            $display("FAIL single_served got cola=%b required 0000", en_cola);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 3; i++) begin
            btn[1] = 1'b1; tick(1);
            btn[1] = 1'b0; tick(1);
        end
        tick(15);
        check_no_write("bounce");
        tests++;
        if (pendiente !== 4'b0000) begin
            fails++;
            $display("FAIL bounce_pend got %b required 0000", pendiente);
        end
    endtask

    task automatic test_round_robin();
        // Pointer sits at 3 after floor 2; floor 0 alone moves it to 1.
        exp_q.push_back(2'd0);
        press(4'b0001);
        check_writes("rr_setup", 1, 5);
        serve(2'd0);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        press(4'b1001);
        check_writes("rr_pair", 2, 5);
        tests++;
        if (last_cyc - first_cyc != 2) begin
            fails++;
            $display("FAIL rr_spacing got %0d required 2", last_cyc - first_cyc);
        end
        serve(2'd3); serve(2'd0);
        // Pointer back at 1: floor 1 must win over floor 0.
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        press(4'b0011);
        check_writes("rr_ptr_end", 2, 5);
        serve(2'd1); serve(2'd0);
    endtask

    task automatic test_full();
        int c0;
        bus.full_fifo = 1'b1;
        press(4'b0010);
        check_no_write("full_hold");
        tests++;
        if (pendiente !== 4'b0010 || en_cola !== 4'b0000) begin
            fails++;
            $display("FAIL full_pend got pend=%b cola=%b required 0010/0000", pendiente, en_cola);
        end
        bus.full_fifo = 1'b0;
        c0 = cyc;
        exp_q.push_back(2'd1);
        check_writes("full_resume", 1, 4);
        tests++;
        if (last_cyc - c0 > 2) begin
            fails++;
            $display("FAIL full_resume_latency got %0d required <=2", last_cyc - c0);
        end
        serve(2'd1);
    endtask

    task automatic test_duplicate();
        exp_q.push_back(2'd2);
        press(4'b0100);
        check_writes("dup_first", 1, 5);
        press(4'b0100);
        check_no_write("dup_second");
        tests++;
        if (descartes !== 8'd1) begin
            fails++;
            $display("FAIL dup_count got %0d required 1", descartes);
        end
        serve(2'd2);
        exp_q.push_back(2'd2);
        press(4'b0100);
        check_writes("dup_after_serve", 1, 5);
        tests++;
        if (en_cola !== 4'b0100 || descartes !== 8'd1) begin
            fails++;
            $display("FAIL dup_after_state got cola=%b desc=%0d required 0100/1", en_cola, descartes);
        end
        serve(2'd2);
    endtask

    task automatic test_reset_mid_write();
        logic seen;
        seen = 1'b0;
        btn[3] = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.wr_en_fifo) seen = 1'b1;
        end
        tests++;
        if (!seen || bus.din_fifo !== 2'd3) begin
            fails++;
            $display("FAIL rst_mid_write got seen=%b din=%0d required 1/3", seen, bus.din_fifo);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.wr_en_fifo !== 1'b0) begin
            fails++;
            $display("FAIL rst_async_wr got %b required 0", bus.wr_en_fifo);
        end
        btn = '0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        tests++;
        if ({bus.wr_en_fifo, bus.din_fifo, pendiente, en_cola, descartes} !== '0) begin
            fails++;
            $display("FAIL rst_after got wr=%b din=%0d pend=%b cola=%b desc=%0d required all 0",
                     bus.wr_en_fifo, bus.din_fifo, pendiente, en_cola, descartes);
        end
        check_no_write("rst_quiet");
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_round_robin();
        test_full();
        test_duplicate();
        test_reset_mid_write();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_leftover got %0d required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
